// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch and memory-wait stall/flush generation
// with a RUN / MEM_WAIT / HALT supervisor, sticky timeout error and a stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [3:0]  ex_reg_dst,
    input  logic        ex_reg_wr,
    input  logic        ex_wb_sel,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        branch_taken,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic [1:0]  state,
    output logic        err,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_q;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       mem_busy;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_reg_wr && ex_wb_sel && (ex_reg_dst != 4'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_reg_dst)) ||
                       (id_rs2_used && (id_rs2 == ex_reg_dst)));
    assign mem_busy = mem_req && !mem_ack;
    assign state    = state_q;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst_n) begin
            if (state_q == HALT) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (mem_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (branch_taken) begin
                // The redirect squashes the younger instruction, so load_use is moot.
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            wait_cnt     <= 8'd0;
            err          <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            if (pc_stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;

            case (state_q)
                RUN: begin
                    wait_cnt <= mem_busy ? wait_cnt + 8'd1 : 8'd0;
                    if (mem_busy)
                        state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        wait_cnt <= 8'd0;
                        state_q  <= RUN;
                    end else if (wait_cnt == TIMEOUT) begin
                        state_q  <= HALT;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q  <= RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs1, id_rs2, ex_reg_dst;
    logic        id_rs1_used, id_rs2_used, ex_reg_wr, ex_wb_sel;
    logic        mem_req, mem_ack, branch_taken;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0]  state;
    logic        err;
    logic [15:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Model: mode 0=run, 1=waiting on memory, 2=halted.
    int m_mode, m_wcnt, m_err, m_scnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_reg_dst(ex_reg_dst), .ex_reg_wr(ex_reg_wr), .ex_wb_sel(ex_wb_sel),
        .mem_req(mem_req), .mem_ack(mem_ack), .branch_taken(branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .state(state), .err(err), .stall_cycles(stall_cycles)
    );

    function automatic logic [7:0] outs_vec();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    function automatic bit m_busy();
        return mem_req && !mem_ack;
    endfunction

    function automatic bit m_load_use();
        bit hit1, hit2;
        hit1 = id_rs1_used && (id_rs1 == ex_reg_dst);
        hit2 = id_rs2_used && (id_rs2 == ex_reg_dst);
        return ex_reg_wr && ex_wb_sel && (ex_reg_dst != 0) && (hit1 || hit2);
    endfunction

    // Bit order: pc, if_id, id_ex, ex_mem stalls, then if_id, id_ex, ex_mem, mem_wb flushes.
    function automatic logic [7:0] m_outs();
        if (!rst_n)         return 8'b0000_0000;
        if (m_mode == 2)    return 8'b1110_0011;
        if (m_busy())       return 8'b1111_0001;
        if (branch_taken)   return 8'b0000_1100;
        if (m_load_use())   return 8'b1100_0100;
        return 8'b0000_0000;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_wcnt = 0; m_err = 0; m_scnt = 0;
    endtask

    task automatic m_clock();
        bit busy;
        busy = m_busy();
        if (m_outs()[7] && m_scnt < 65535) m_scnt++;
        if (m_mode == 0) begin
            if (busy) m_mode = 1;
            m_wcnt = busy ? m_wcnt + 1 : 0;
        end else if (m_mode == 1) begin
            if (!busy) begin
                m_mode = 0; m_wcnt = 0;
            end else if (m_wcnt == TIMEOUT) begin
                m_mode = 2; m_err = 1;
            end else begin
                m_wcnt++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2, input logic u2,
                         input logic [3:0] dst, input logic wr, input logic sel,
                         input logic req, input logic ack, input logic br);
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        ex_reg_dst = dst; ex_reg_wr = wr; ex_wb_sel = sel;
        mem_req = req; mem_ack = ack; branch_taken = br;
    endtask

    // Inputs are already driven; check outputs, clock once, check registered state.
    task automatic step(input string tag);
        #1;
        check({tag, "/outs"}, 32'(outs_vec()), 32'(m_outs()));
        @(posedge clk);
        m_clock();
        #1;
        check({tag, "/state"}, 32'(state), 32'(m_mode));
        check({tag, "/err"}, 32'(err), 32'(m_err));
        check({tag, "/stall_cycles"}, 32'(stall_cycles), 32'(m_scnt));
    endtask

    // Reset asserted between edges, with a load-use pattern on the inputs.
    task automatic mid_reset(input string tag);
        #2;
        drive(4'd5, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        m_reset();
        #1;
        check({tag, "/outs"}, 32'(outs_vec()), 32'd0);
        check({tag, "/state"}, 32'(state), 32'd0);
        check({tag, "/err"}, 32'(err), 32'd0);
        check({tag, "/stall_cycles"}, 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        m_reset();
        drive(4'd5, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #7;
        check("reset/outs", 32'(outs_vec()), 32'd0);
        check("reset/state", 32'(state), 32'd0);
        check("reset/err", 32'(err), 32'd0);
        check("reset/stall_cycles", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs2: one stall cycle.
        drive(4'd1, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("load_use/vec", 32'(outs_vec()), 32'b1100_0100);
        step("load_use");
        check("load_use/count", 32'(stall_cycles), 32'd1);

        // r0 destination never hazards.
        drive(4'd0, 1'b1, 4'd5, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("r0/vec", 32'(outs_vec()), 32'd0);
        step("r0");

        // Branch wins over load-use.
        drive(4'd1, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 check("branch/vec", 32'(outs_vec()), 32'b0000_1100);
        step("branch");

        // Three memory-wait cycles then ack.
        mid_reset("rst_a");
        for (int i = 0; i < 3; i++) begin
            drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #1 check($sformatf("memwait%0d/vec", i), 32'(outs_vec()), 32'b1111_0001);
            step($sformatf("memwait%0d", i));
            check($sformatf("memwait%0d/st", i), 32'(state), 32'd1);
        end
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("memack");
        check("memack/st", 32'(state), 32'd0);
        check("memack/count", 32'(stall_cycles), 32'd3);

        // Timeout into HALT after the 5th busy edge.
        mid_reset("rst_b");
        for (int i = 1; i <= 6; i++) begin
            drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step($sformatf("timeout%0d", i));
            check($sformatf("timeout%0d/st", i), 32'(state), (i >= 5) ? 32'd2 : 32'd1);
            check($sformatf("timeout%0d/err", i), 32'(err), (i >= 5) ? 32'd1 : 32'd0);
        end
        drive(4'd1, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #1 check("halt/vec", 32'(outs_vec()), 32'b1110_0011);
        step("halt_ack");
        check("halt_ack/st", 32'(state), 32'd2);
        check("halt_ack/err", 32'(err), 32'd1);

        // Reset between edges while halted.
        mid_reset("rst_halt");
        drive(4'd1, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("post_reset_lu");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
                  4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            step($sformatf("rand%0d", i));
            if (m_mode == 2 && $urandom_range(0, 3) == 0)
                mid_reset($sformatf("rand_rst%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of consecutive memory-wait cycles before HALT (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port id_rs1 / id_rs2, input, 4 each, the ID-stage source register indices.
REQ-005 SHALL have port id_rs1_used / id_rs2_used, input, 1 each, meaning the corresponding source is actually read.
REQ-006 SHALL have ports ex_reg_dst (input, 4), ex_reg_wr (input, 1) and ex_wb_sel (input, 1), the EX-stage destination, write enable and load select (1 = load).
REQ-007 SHALL have port mem_req, input, 1, meaning the MEM stage is performing a memory access this cycle.
REQ-008 SHALL have port mem_ack, input, 1, meaning memory completes the access this cycle.
REQ-009 SHALL have port branch_taken, input, 1, meaning the EX stage redirects the PC.
REQ-010 SHALL have outputs pc_stall, if_id_stall, id_ex_stall and ex_mem_stall, each 1 bit, the stage hold enables.
REQ-011 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_flush and mem_wb_flush, each 1 bit, the stage bubble-insert enables.
REQ-012 SHALL have output state, 2 bits: RUN=00, MEM_WAIT=01, HALT=10.
REQ-013 SHALL have output err, 1 bit, a sticky memory-timeout flag.
REQ-014 SHALL have output stall_cycles, 16 bits, a saturating count of cycles with pc_stall=1.

Function
REQ-015 SHALL compute all stall/flush outputs combinationally from the registered state and the current inputs, so there is zero-cycle latency.
REQ-016 SHALL define load_use = ex_reg_wr & ex_wb_sel & (ex_reg_dst != 0) & ((id_rs1_used & id_rs1 == ex_reg_dst) | (id_rs2_used & id_rs2 == ex_reg_dst)).
REQ-017 SHALL define mem_busy = mem_req & !mem_ack.
REQ-018 SHALL apply the following per-cycle priority in state RUN (highest first): mem_busy, branch_taken, load_use.
REQ-019 SHALL, when mem_busy in RUN or MEM_WAIT, assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush, and assert no other flush.
REQ-020 SHALL, when branch_taken without mem_busy, assert if_id_flush and id_ex_flush with no stalls asserted; load_use is ignored in that cycle.
REQ-021 SHALL, when load_use only, assert pc_stall, if_id_stall and id_ex_flush for exactly that cycle.
REQ-022 SHALL never assert ex_mem_flush except in HALT.
REQ-023 SHALL transition RUN->MEM_WAIT on mem_busy.
REQ-024 SHALL transition MEM_WAIT->RUN on a cycle with mem_ack=1 or mem_req=0.
REQ-025 SHALL transition MEM_WAIT->HALT when wait_cnt == MEM_TIMEOUT and mem_busy is still asserted.
REQ-026 SHALL keep an internal 8-bit wait_cnt that increments on every mem_busy cycle and clears to 0 on any cycle without mem_busy.
REQ-027 SHALL treat the cycle mem_ack arrives as a normal RUN cycle, evaluating branch and load_use priorities on it.
REQ-028 SHALL treat HALT as terminal: pc_stall, if_id_stall and id_ex_stall=1, plus ex_mem_flush and mem_wb_flush=1, with all inputs ignored until rst_n.
REQ-029 SHALL set err=1 on entry to HALT and hold it until reset.
REQ-030 SHALL increment stall_cycles on each clock edge where pc_stall=1, saturating at 16'hFFFF with no wrap-around.

Reset
REQ-031 SHALL, while rst_n=0, set state=RUN, wait_cnt=0, err=0 and stall_cycles=0, and force all eight stall/flush outputs to 0 regardless of inputs.
REQ-032 SHALL, on reset asserted mid-MEM_WAIT or mid-HALT, reach RUN immediately without waiting for a clock edge; the first post-reset edge evaluates the inputs as in RUN.

Verification
REQ-033 SHALL cover load-use: ex_reg_wr=1, ex_wb_sel=1, ex_reg_dst=5, id_rs2=5, id_rs2_used=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cycles goes 0->1.
REQ-034 SHALL cover the r0 exemption: the same stimulus with ex_reg_dst=0 and id_rs1=0 -> all outputs 0.
REQ-035 SHALL cover branch over load-use: branch_taken=1 with a load_use condition -> if_id_flush=1, id_ex_flush=1 and pc_stall=0.
REQ-036 SHALL cover memory wait: mem_req=1 and mem_ack=0 for 3 cycles, then mem_ack=1 -> state=01 for 3 cycles with four stalls plus mem_wb_flush each cycle, then state=00; stall_cycles=3.
REQ-037 SHALL cover timeout: with MEM_TIMEOUT=4, hold mem_busy for 6 cycles -> state=10 and err=1 after the 5th edge, holding even after mem_ack=1.
REQ-038 SHALL cover reset recovery: assert rst_n=0 between clock edges in HALT -> state=00, err=0, stall_cycles=0 and all stall/flush outputs 0 immediately.
